// File: rtl/wired_lsu_mem_stage_if.sv
// Bus bundle for the LSU memory stage: issue-queue request and response,
// plus the D-cache request and response port.
interface wired_lsu_mem_stage_if;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_msize_i;
  logic        req_signed_i;
  logic        req_store_i;
  logic        dc_req_valid_o;
  logic        dc_req_ready_i;
  logic [31:0] dc_req_addr_o;
  logic        dc_req_we_o;
  logic [3:0]  dc_req_strb_o;
  logic [31:0] dc_req_wdata_o;
  logic        dc_resp_valid_i;
  logic [31:0] dc_resp_rdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [31:0] resp_vaddr_o;
  logic        resp_excp_o;

  modport slave (
    input  flush_i, req_valid_i, req_vaddr_i, req_wdata_i, req_msize_i,
           req_signed_i, req_store_i, dc_req_ready_i, dc_resp_valid_i,
           dc_resp_rdata_i, resp_ready_i,
    output req_ready_o, dc_req_valid_o, dc_req_addr_o, dc_req_we_o,
           dc_req_strb_o, dc_req_wdata_o, resp_valid_o, resp_rdata_o,
           resp_vaddr_o, resp_excp_o
  );

  modport master (
    output flush_i, req_valid_i, req_vaddr_i, req_wdata_i, req_msize_i,
           req_signed_i, req_store_i, dc_req_ready_i, dc_resp_valid_i,
           dc_resp_rdata_i, resp_ready_i,
    input  req_ready_o, dc_req_valid_o, dc_req_addr_o, dc_req_we_o,
           dc_req_strb_o, dc_req_wdata_o, resp_valid_o, resp_rdata_o,
           resp_vaddr_o, resp_excp_o
  );
endinterface

// File: rtl/wired_lsu_mem_stage.sv
// In-order LSU memory stage: alignment check, strobe/data formatting, D-cache
// issue, outstanding-access tracking and in-order load-data extraction.
module wired_lsu_mem_stage #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wired_lsu_mem_stage_if.slave  bus
);
  localparam int unsigned PTR_LEN = $clog2(DEPTH);
  localparam int unsigned DROP_W  = PTR_LEN + 4;

  typedef logic [PTR_LEN-1:0] ptr_t;
  typedef logic [PTR_LEN:0]   cnt_t;
  typedef logic [DROP_W-1:0]  drop_t;

  typedef struct packed {
    logic [1:0]  off;
    logic [1:0]  msize;
    logic        sgn;
    logic        store;
    logic        excp;
    logic [31:0] vaddr;
  } meta_t;

  meta_t       r_meta_mem [DEPTH];
  ptr_t        r_meta_wptr, r_meta_rptr;
  cnt_t        r_meta_cnt;
  logic [31:0] r_data_mem [DEPTH];
  ptr_t        r_data_wptr, r_data_rptr;
  cnt_t        r_data_cnt;
  cnt_t        r_inflight;
  drop_t       r_drop_cnt;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_resp_vaddr;
  logic        r_resp_excp;

  logic        w_misaligned, w_space, w_dc_valid, w_req_ready;
  logic        w_accept, w_dc_fire;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  meta_t       w_new_meta, w_head;
  logic        w_meta_empty, w_head_valid, w_data_empty, w_resp_take, w_data_avail;
  logic [31:0] w_data_head, w_shift, w_ext;
  logic        w_out_free, w_pop;
  logic        w_meta_push, w_meta_pop, w_data_use, w_data_push, w_data_pop;

  // Request side
  assign w_misaligned = ((bus.req_msize_i == 2'd1) & bus.req_vaddr_i[0]) |
                        (bus.req_msize_i[1] & (bus.req_vaddr_i[1:0] != 2'b00));
  assign w_space      = (r_meta_cnt != cnt_t'(DEPTH)) & (r_inflight < cnt_t'(DEPTH));
  assign w_dc_valid   = rst_n & bus.req_valid_i & !w_misaligned & w_space & !bus.flush_i;
  assign w_req_ready  = rst_n & w_space & !bus.flush_i & (w_misaligned | bus.dc_req_ready_i);
  assign w_accept     = bus.req_valid_i & w_req_ready;
  assign w_dc_fire    = w_dc_valid & bus.dc_req_ready_i;

  always_comb begin
    w_strb  = 4'hF;
    w_wdata = bus.req_wdata_i;
    case (bus.req_msize_i)
      2'd0: begin
        w_strb  = 4'b0001 << bus.req_vaddr_i[1:0];
        w_wdata = {4{bus.req_wdata_i[7:0]}};
      end
      2'd1: begin
        w_strb  = 4'b0011 << bus.req_vaddr_i[1:0];
        w_wdata = {2{bus.req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus.req_ready_o    = w_req_ready;
  assign bus.dc_req_valid_o = w_dc_valid;
  assign bus.dc_req_addr_o  = rst_n ? {bus.req_vaddr_i[31:2], 2'b00} : '0;
  assign bus.dc_req_we_o    = rst_n & bus.req_store_i;
  assign bus.dc_req_strb_o  = rst_n ? w_strb : '0;
  assign bus.dc_req_wdata_o = rst_n ? w_wdata : '0;

  assign w_new_meta = '{off:   bus.req_vaddr_i[1:0],
                        msize: bus.req_msize_i,
                        sgn:   bus.req_signed_i,
                        store: bus.req_store_i,
                        excp:  w_misaligned,
                        vaddr: bus.req_vaddr_i};

  // Completion: empty FIFOs are bypassed so a misaligned request or a cache
  // response can reach the output register in the cycle it arrives.
  assign w_meta_empty = (r_meta_cnt == '0);
  assign w_head_valid = !w_meta_empty | (w_accept & w_misaligned);
  assign w_head       = w_meta_empty ? w_new_meta : r_meta_mem[r_meta_rptr];
  assign w_data_empty = (r_data_cnt == '0);
  assign w_resp_take  = bus.dc_resp_valid_i & (r_drop_cnt == '0);
  assign w_data_avail = !w_data_empty | w_resp_take;
  assign w_data_head  = w_data_empty ? bus.dc_resp_rdata_i : r_data_mem[r_data_rptr];
  assign w_out_free   = !r_resp_valid | bus.resp_ready_i;
  assign w_pop        = w_head_valid & w_out_free & (w_head.excp | w_data_avail);

  assign w_meta_push  = w_accept & !(w_pop & w_meta_empty);
  assign w_meta_pop   = w_pop & !w_meta_empty;
  assign w_data_use   = w_pop & !w_head.excp;
  assign w_data_push  = w_resp_take & !(w_data_use & w_data_empty);
  assign w_data_pop   = w_data_use & !w_data_empty;

  always_comb begin
    w_shift = w_data_head >> {w_head.off, 3'b000};
    case (w_head.msize)
      2'd0:    w_ext = {{24{w_head.sgn & w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_ext = {{16{w_head.sgn & w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
    if (w_head.store | w_head.excp) w_ext = '0;
  end

  always_ff @(posedge clk) begin
    if (w_meta_push & !bus.flush_i) r_meta_mem[r_meta_wptr] <= w_new_meta;
    if (w_data_push & !bus.flush_i) r_data_mem[r_data_wptr] <= bus.dc_resp_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta_wptr <= '0;
      r_meta_rptr <= '0;
      r_meta_cnt  <= '0;
      r_data_wptr <= '0;
      r_data_rptr <= '0;
      r_data_cnt  <= '0;
    end else if (bus.flush_i) begin
      r_meta_wptr <= '0;
      r_meta_rptr <= '0;
      r_meta_cnt  <= '0;
      r_data_wptr <= '0;
      r_data_rptr <= '0;
      r_data_cnt  <= '0;
    end else begin
      if (w_meta_push) r_meta_wptr <= r_meta_wptr + ptr_t'(1);
      if (w_meta_pop)  r_meta_rptr <= r_meta_rptr + ptr_t'(1);
      if (w_data_push) r_data_wptr <= r_data_wptr + ptr_t'(1);
      if (w_data_pop)  r_data_rptr <= r_data_rptr + ptr_t'(1);
      r_meta_cnt <= r_meta_cnt + cnt_t'(w_meta_push) - cnt_t'(w_meta_pop);
      r_data_cnt <= r_data_cnt + cnt_t'(w_data_push) - cnt_t'(w_data_pop);
    end
  end

  // Responses still owed by the cache at a flush are discarded as they return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_inflight <= r_inflight + cnt_t'(w_dc_fire) - cnt_t'(bus.dc_resp_valid_i);
      if (bus.flush_i)
        r_drop_cnt <= r_drop_cnt + drop_t'(r_inflight) - drop_t'(bus.dc_resp_valid_i);
      else if (bus.dc_resp_valid_i && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - drop_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_vaddr <= '0;
      r_resp_excp  <= 1'b0;
    end else if (bus.flush_i) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_vaddr <= '0;
      r_resp_excp  <= 1'b0;
    end else if (w_pop) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= w_ext;
      r_resp_vaddr <= w_head.vaddr;
      r_resp_excp  <= w_head.excp;
    end else if (bus.resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_rdata_o = r_resp_rdata;
  assign bus.resp_vaddr_o = r_resp_vaddr;
  assign bus.resp_excp_o  = r_resp_excp;
endmodule

// File: tb/tb_wired_lsu_mem_stage.sv
// Self-checking bench for wired_lsu_mem_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_wired_lsu_mem_stage;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wired_lsu_mem_stage_if bus ();
  wired_lsu_mem_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on access size and byte offset.
  function automatic int unsigned m_size(input logic [1:0] msize);
    return (msize == 2'd0) ? 1 : (msize == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] msize);
    return (a % m_size(msize)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [1:0] msize);
    int unsigned n = m_size(msize);
    return 4'(((32'd1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [1:0] msize);
    int unsigned n = m_size(msize);
    if (n == 1) return (w & 32'hFF) * 32'h01010101;
    if (n == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] word, input logic [31:0] a,
                                          input logic [1:0] msize, input logic sgn,
                                          input logic store, input logic mis);
    logic [31:0] v;
    int unsigned n = m_size(msize);
    if (store || mis) return 32'd0;
    v = word >> (8 * (a % 4));
    if (n == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  task automatic idle();
    bus.flush_i         = 1'b0;
    bus.req_valid_i     = 1'b0;
    bus.req_vaddr_i     = '0;
    bus.req_wdata_i     = '0;
    bus.req_msize_i     = '0;
    bus.req_signed_i    = 1'b0;
    bus.req_store_i     = 1'b0;
    bus.dc_req_ready_i  = 1'b1;
    bus.dc_resp_valid_i = 1'b0;
    bus.dc_resp_rdata_i = '0;
    bus.resp_ready_i    = 1'b1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] ms,
                           input logic sgn, input logic st);
    bus.req_valid_i  = 1'b1;
    bus.req_vaddr_i  = a;
    bus.req_wdata_i  = wd;
    bus.req_msize_i  = ms;
    bus.req_signed_i = sgn;
    bus.req_store_i  = st;
  endtask

  typedef struct {
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic [1:0]  msize;
    logic        sgn;
    logic        store;
    logic [31:0] word;
    logic [3:0]  strb;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    logic        excp;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive_req(v.vaddr, v.wdata, v.msize, v.sgn, v.store);
    #1;
    check("vec_req_ready", bus.req_ready_o, 1);
    check("vec_dc_valid", bus.dc_req_valid_o, !v.excp);
    if (!v.excp) begin
      check("vec_dc_addr", bus.dc_req_addr_o, v.vaddr & 32'hFFFFFFFC);
      check("vec_dc_strb", bus.dc_req_strb_o, v.strb);
      check("vec_dc_wdata", bus.dc_req_wdata_o, v.dwdata);
      check("vec_dc_we", bus.dc_req_we_o, v.store);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1;
    if (!v.excp) begin
      check("vec_resp_early", bus.resp_valid_o, 0);
      @(negedge clk);
      @(negedge clk);
      bus.dc_resp_valid_i = 1'b1;
      bus.dc_resp_rdata_i = v.word;
      @(negedge clk);
      bus.dc_resp_valid_i = 1'b0;
      #1;
    end
    check("vec_resp_valid", bus.resp_valid_o, 1);
    check("vec_resp_rdata", bus.resp_rdata_o, v.rdata);
    check("vec_resp_vaddr", bus.resp_vaddr_o, v.vaddr);
    check("vec_resp_excp", bus.resp_excp_o, v.excp);
    @(negedge clk);
    #1;
    check("vec_resp_drained", bus.resp_valid_o, 0);
  endtask

  typedef struct { logic [31:0] rdata; logic [31:0] vaddr; logic excp; } exp_t;
  typedef struct { int unsigned due; logic [31:0] data; } cq_t;
  exp_t expq[$];
  cq_t  cq[$];

  initial begin
    int unsigned cyc, last_due, due;
    logic        prev_hold, prev_excp, mis;
    logic [31:0] prev_rdata, prev_vaddr, word;
    exp_t        e;

    vecs[0]  = '{32'h1000, 32'h0,        2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{32'h1003, 32'h0,        2'd0, 1'b1, 1'b0, 32'h80FF1234, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{32'h1002, 32'h0,        2'd1, 1'b0, 1'b0, 32'h80FF1234, 4'hC, 32'h0,        32'h000080FF, 1'b0};
    vecs[3]  = '{32'h2002, 32'h0000ABCD, 2'd1, 1'b0, 1'b1, 32'h55555555, 4'hC, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[4]  = '{32'h1001, 32'h0,        2'd0, 1'b0, 1'b0, 32'h12345678, 4'h2, 32'h0,        32'h00000056, 1'b0};
    vecs[5]  = '{32'h1000, 32'h0,        2'd1, 1'b1, 1'b0, 32'h1234F00D, 4'h3, 32'h0,        32'hFFFFF00D, 1'b0};
    vecs[6]  = '{32'h2001, 32'h123456A5, 2'd0, 1'b0, 1'b1, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[7]  = '{32'h2000, 32'hCAFEF00D, 2'd2, 1'b0, 1'b1, 32'h0,        4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    vecs[8]  = '{32'h1001, 32'h0,        2'd2, 1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{32'h1003, 32'h0,        2'd1, 1'b1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{32'h1004, 32'h0,        2'd3, 1'b0, 1'b0, 32'h01020304, 4'hF, 32'h0,        32'h01020304, 1'b0};
    vecs[11] = '{32'h1002, 32'h0,        2'd0, 1'b1, 1'b0, 32'h007F0000, 4'h4, 32'h0,        32'h0000007F, 1'b0};
    vecs[12] = '{32'h2000, 32'hFFFF1234, 2'd1, 1'b0, 1'b1, 32'h0,        4'h3, 32'h12341234, 32'h0,        1'b0};
    vecs[13] = '{32'h1002, 32'h0,        2'd1, 1'b1, 1'b0, 32'h7FFF0000, 4'hC, 32'h0,        32'h00007FFF, 1'b0};

    // Reset: outputs forced low even with a request presented.
    idle();
    rst_n = 1'b0;
    drive_req(32'h1234, 32'hFFFFFFFF, 2'd2, 1'b0, 1'b1);
    #12;
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_dc_valid", bus.dc_req_valid_o, 0);
    check("rst_dc_addr", bus.dc_req_addr_o, 0);
    check("rst_dc_strb", bus.dc_req_strb_o, 0);
    check("rst_dc_wdata", bus.dc_req_wdata_o, 0);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_resp_rdata", bus.resp_rdata_o, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Exception queued behind a slower cache load stays in order.
    @(negedge clk);
    drive_req(32'h1000, 32'h0, 2'd2, 1'b0, 1'b0);
    #1 check("ord_dc_valid0", bus.dc_req_valid_o, 1);
    @(negedge clk);
    drive_req(32'h1001, 32'h0, 2'd2, 1'b0, 1'b0);
    #1 check("ord_dc_valid1", bus.dc_req_valid_o, 0);
    check("ord_ready1", bus.req_ready_o, 1);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    #1 check("ord_wait0", bus.resp_valid_o, 0);
    @(negedge clk);
    #1 check("ord_wait1", bus.resp_valid_o, 0);
    @(negedge clk);
    bus.dc_resp_valid_i = 1'b1;
    bus.dc_resp_rdata_i = 32'hDEADBEEF;
    #1 check("ord_wait2", bus.resp_valid_o, 0);
    @(negedge clk);
    bus.dc_resp_valid_i = 1'b0;
    #1 check("ord_first_valid", bus.resp_valid_o, 1);
    check("ord_first_vaddr", bus.resp_vaddr_o, 32'h1000);
    check("ord_first_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
    @(negedge clk);
    #1 check("ord_second_valid", bus.resp_valid_o, 1);
    check("ord_second_vaddr", bus.resp_vaddr_o, 32'h1001);
    check("ord_second_excp", bus.resp_excp_o, 1);
    check("ord_second_rdata", bus.resp_rdata_o, 0);
    @(negedge clk);
    #1 check("ord_idle", bus.resp_valid_o, 0);

    // Fill to DEPTH with the cache silent, then back-pressure the output.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive_req(32'h4000 + 32'(4 * i), 32'h0, 2'd2, 1'b0, 1'b0);
      #1 check("full_accept", bus.req_ready_o, 1);
    end
    @(negedge clk);
    drive_req(32'h4010, 32'h0, 2'd2, 1'b0, 1'b0);
    #1 check("full_ready_low", bus.req_ready_o, 0);
    check("full_dc_low", bus.dc_req_valid_o, 0);
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      bus.req_valid_i     = 1'b0;
      bus.resp_ready_i    = 1'b0;
      bus.dc_resp_valid_i = (i < DEPTH);
      bus.dc_resp_rdata_i = 32'hA0000000 + 32'(i);
      #1;
      if (i > 0) begin
        check("hold_valid", bus.resp_valid_o, 1);
        check("hold_vaddr", bus.resp_vaddr_o, 32'h4000);
        check("hold_rdata", bus.resp_rdata_o, 32'hA0000000);
      end
    end
    @(negedge clk);
    bus.dc_resp_valid_i = 1'b0;
    bus.resp_ready_i    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      #1 check("drain_valid", bus.resp_valid_o, 1);
      check("drain_vaddr", bus.resp_vaddr_o, 32'h4000 + 32'(4 * i));
      check("drain_rdata", bus.resp_rdata_o, 32'hA0000000 + 32'(i));
    end
    @(negedge clk);
    #1 check("drain_idle", bus.resp_valid_o, 0);

    // Flush with a held response and three loads in flight.
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    drive_req(32'h3101, 32'h0, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_req(32'h3100 + 32'(4 * i), 32'h0, 2'd2, 1'b0, 1'b0);
      #1 check("fl_load_dc", bus.dc_req_valid_o, 1);
      check("fl_held_valid", bus.resp_valid_o, 1);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b1;
    #1 check("fl_ready_low", bus.req_ready_o, 0);
    @(negedge clk);
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b1;
    drive_req(32'h3000, 32'h0, 2'd2, 1'b0, 1'b0);
    #1 check("fl_cleared", bus.resp_valid_o, 0);
    check("fl_new_accept", bus.dc_req_valid_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid_i     = 1'b0;
      bus.dc_resp_valid_i = 1'b1;
      bus.dc_resp_rdata_i = (i < 3) ? 32'hBAD00000 + 32'(i) : 32'h3000C0DE;
      #1 check("fl_discard", bus.resp_valid_o, 0);
    end
    @(negedge clk);
    bus.dc_resp_valid_i = 1'b0;
    #1 check("fl_new_valid", bus.resp_valid_o, 1);
    check("fl_new_rdata", bus.resp_rdata_o, 32'h3000C0DE);
    check("fl_new_vaddr", bus.resp_vaddr_o, 32'h3000);
    @(negedge clk);
    #1 check("fl_idle", bus.resp_valid_o, 0);

    // Randomized traffic against the queue model with an in-order cache model.
    cyc = 0;
    last_due = 0;
    prev_hold = 1'b0;
    prev_rdata = '0;
    prev_vaddr = '0;
    prev_excp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cq.size() > 0 && cq[0].due <= cyc) begin
        bus.dc_resp_valid_i = 1'b1;
        bus.dc_resp_rdata_i = cq[0].data;
        void'(cq.pop_front());
      end else begin
        bus.dc_resp_valid_i = 1'b0;
        bus.dc_resp_rdata_i = $urandom;
      end
      bus.req_valid_i    = (i < 2700) && ($urandom_range(0, 9) < 6);
      bus.req_vaddr_i    = 32'h5000 | 32'($urandom_range(0, 255));
      bus.req_wdata_i    = $urandom;
      bus.req_msize_i    = 2'($urandom_range(0, 3));
      bus.req_signed_i   = 1'($urandom_range(0, 1));
      bus.req_store_i    = 1'($urandom_range(0, 1));
      bus.dc_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.resp_ready_i   = (i >= 2700) || ($urandom_range(0, 9) < 7);
      #1;
      if (prev_hold) begin
        check("rnd_hold_valid", bus.resp_valid_o, 1);
        check("rnd_hold_rdata", bus.resp_rdata_o, prev_rdata);
        check("rnd_hold_vaddr", bus.resp_vaddr_o, prev_vaddr);
        check("rnd_hold_excp", bus.resp_excp_o, prev_excp);
      end
      mis = m_mis(bus.req_vaddr_i, bus.req_msize_i);
      if (bus.dc_req_valid_o) begin
        check("rnd_dc_cond", bus.req_valid_i & !mis, 1);
        check("rnd_dc_addr", bus.dc_req_addr_o, bus.req_vaddr_i & 32'hFFFFFFFC);
        check("rnd_dc_strb", bus.dc_req_strb_o, m_strb(bus.req_vaddr_i, bus.req_msize_i));
        check("rnd_dc_wdata", bus.dc_req_wdata_o, m_wdata(bus.req_wdata_i, bus.req_msize_i));
        check("rnd_dc_we", bus.dc_req_we_o, bus.req_store_i);
      end else if (bus.req_valid_i && !mis && bus.dc_req_ready_i) begin
        check("rnd_ready_vs_dc", bus.req_ready_o, 0);
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
        word = $urandom;
        expq.push_back('{m_rdata(word, bus.req_vaddr_i, bus.req_msize_i, bus.req_signed_i,
                                 bus.req_store_i, mis), bus.req_vaddr_i, mis});
        if (!mis) begin
          due = cyc + 1 + 32'($urandom_range(0, 3));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          cq.push_back('{due, bus.req_store_i ? $urandom : word});
        end
      end
      if (bus.resp_valid_o && bus.resp_ready_i) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_resp", bus.resp_valid_o, 0);
        end else begin
          e = expq.pop_front();
          check("rnd_resp_rdata", bus.resp_rdata_o, e.rdata);
          check("rnd_resp_vaddr", bus.resp_vaddr_o, e.vaddr);
          check("rnd_resp_excp", bus.resp_excp_o, e.excp);
        end
      end
      prev_hold  = bus.resp_valid_o & !bus.resp_ready_i;
      prev_rdata = bus.resp_rdata_o;
      prev_vaddr = bus.resp_vaddr_o;
      prev_excp  = bus.resp_excp_o;
      cyc++;
    end
    check("rnd_all_delivered", 32'(expq.size()), 0);
    check("rnd_cache_drained", 32'(cq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wired_lsu_mem_stage.md
Name: wired_lsu_mem_stage

Overview:
- In-order memory-access stage directly downstream of the LSU issue queue.
- Accepts one load/store request per cycle and checks alignment.
- Formats byte strobes and store data, then issues the request to the D-cache port.
- Tracks outstanding accesses in a metadata FIFO, extracts and extends load data, and returns one in-order response per request to the issue queue's commit path.

Parameters:
DEPTH, 4, max requests tracked (metadata FIFO depth and in-flight cache-request limit); power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous pipeline flush
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_vaddr_i  in  32  virtual/physical byte address
req_wdata_i  in  32  store data, LSB-aligned
req_msize_i  in  2  0=byte 1=half 2=word 3=treated as word
req_signed_i  in  1  sign-extend load result
req_store_i  in  1  1=store 0=load
dc_req_valid_o  out  1  D-cache request valid
dc_req_ready_i  in  1  D-cache request ready
dc_req_addr_o  out  32  {vaddr[31:2],2'b00}
dc_req_we_o  out  1  store
dc_req_strb_o  out  4  byte enables
dc_req_wdata_o  out  32  lane-replicated store data
dc_resp_valid_i  in  1  D-cache response, one per accepted request, in order, no backpressure
dc_resp_rdata_i  in  32  word read data (ignored for stores)
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response ready
resp_rdata_o  out  32  extended load data (0 for stores/exceptions)
resp_vaddr_o  out  32  original request address
resp_excp_o  out  1  misaligned-address exception (ALE)

Behaviour:
- Reset (async, rst_n=0): meta FIFO, data FIFO and output register empty; inflight=0, drop_cnt=0. resp_valid_o=0, req_ready_o=0, dc_req_valid_o=0, all data outputs 0.
- Misaligned: msize=1 with vaddr[0]=1, or msize>=2 with vaddr[1:0]!=0.
- space = meta FIFO not full AND inflight<DEPTH.
- dc_req_valid_o = req_valid_i & !misaligned & space & !flush_i.
- req_ready_o = space & !flush_i & (misaligned | dc_req_ready_i). Both are combinational.
- On acceptance, push {off=vaddr[1:0], msize, signed, store, excp=misaligned, vaddr} to the meta FIFO. A misaligned request never reaches the cache.
- Strobe/data, off=vaddr[1:0]:
  - byte: strb=1<<off, wdata={4{wdata[7:0]}}.
  - half: strb=3<<off, wdata={2{wdata[15:0]}}.
  - word: strb=4'hF, wdata as given.
- inflight: +1 on dc_req fire, -1 on dc_resp_valid_i. Simultaneous events net to 0.
- D-cache response handling:
  - drop_cnt>0: discard the response, drop_cnt-1.
  - drop_cnt=0: push rdata into the data FIFO (depth DEPTH). It cannot overflow because entries are bounded by meta occupancy.
- Completion: the meta head pops when the output register is free or is draining this cycle (resp_ready_i), and the head has excp=1 or the data FIFO is non-empty. A non-excp pop also pops the data FIFO.
- Load extract, d=rdata>>(8*off):
  - byte → d[7:0] extended.
  - half → d[15:0] extended.
  - word → d.
  - Extension is sign if signed=1, else zero.
  - store/excp → rdata=0.
- Output register: resp_* held stable while resp_valid_o&!resp_ready_i. Back-to-back completions sustain 1/cycle.
- Latency:
  - misaligned request accepted in cycle N → resp_valid_o in N+1 (if the path is idle).
  - dc_resp_valid_i in cycle M → resp_valid_o in M+1.
- Ordering: responses are strictly in acceptance order, including exceptions interleaved with cache accesses.
- flush_i (synchronous, priority over all updates):
  - clears both FIFOs and the output register (resp_valid_o=0 next cycle).
  - drop_cnt <= drop_cnt + inflight − (dc_resp_valid_i?1:0).
  - inflight keeps counting normally.
- Requests are accepted while drop_cnt>0. Their responses arrive after the dropped ones.
- Pointer wrap-around: FIFO pointers are PTR_LEN bits with a separate count of PTR_LEN+1 bits. Full = count==DEPTH.

Test Plan:
1. Load word at 0x1000, cache returns 0xDEADBEEF 2 cycles later → dc_req_addr=0x1000, strb=F, we=0; resp one cycle after dc_resp: rdata=0xDEADBEEF, excp=0.
2. Signed byte load at 0x1003, rdata=0x80FF1234 → strb=8; resp rdata=0xFFFFFF80. Unsigned half at 0x1002 → strb=C, rdata=0x000080FF.
3. Store half 0xABCD at 0x2002 → dc_req_strb=C, wdata=0xABCDABCD, we=1; after cache ack resp rdata=0, excp=0.
4. Load word 0x1000 (cache delay 3), then word at 0x1001 issued next cycle → no dc request for the second; responses in order: 0x1000 data first, then excp=1 vaddr=0x1001.
5. Issue DEPTH loads with cache stalled; then one more → req_ready_o=0. Hold resp_ready_i=0 with 2 completions pending → output stable, no loss, all DEPTH delivered once released.
6. 3 loads in flight, flush_i pulsed → resp_valid_o=0. The 3 late cache responses are discarded; a new load at 0x3000 issued after the flush returns its own data, unpolluted.
